// File: rtl/mac_sequencer.sv
// mac_sequencer
//   Operand-feeding and result-consuming stage around an 8x8 sequential
//   signed multiplier. Operand pairs arrive on a valid/ready stream and are
//   issued to the multiplier one at a time. Each product is sign-extended and
//   accumulated into a signed dot-product register. The finished sum is then
//   presented on a valid/ready output.
//
// Parameters
//   ACC_W      accumulator/result width, signed (>= 16)
//   MAX_TERMS  terms per dot product before forced termination (1..255)
//
// Configuration macro
//   SATURATE_EN  defined: an overflowing accumulate clamps to the signed
//                ACC_W limit on the addend side.
//                undefined: the accumulator wraps modulo 2^ACC_W.
//                In both cases the sticky overflow flag is set.
//
// Ports
//   clock        single clock, all logic on posedge
//   reset        synchronous, active-high
//   in_valid     operand pair valid
//   in_ready     pair accepted when in_valid & in_ready
//   in_a         signed operand A
//   in_b         operand B, passed through to multiplier DataB
//   in_last      pair is the final term of this dot product
//   mul_start    multiplier start
//   mul_a        multiplier DataA (registered)
//   mul_b        multiplier DataB (registered)
//   mul_product  multiplier product, signed
//   mul_done     multiplier done
//   acc_valid    result valid
//   acc_ready    result consumed when acc_valid & acc_ready
//   acc_result   accumulated sum
//   acc_count    number of terms in acc_result
//   overflow     sticky: an accumulate exceeded the signed ACC_W range

module mac_sequencer #(
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned MAX_TERMS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic             mul_start,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_product,
  input  logic             mul_done,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_result,
  output logic [7:0]       acc_count,
  output logic             overflow
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_RELEASE = 3'd2,
    S_ACCUM   = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  state_t           state;
  logic             last_q;
  logic [15:0]      prod_q;

  logic [ACC_W-1:0] prod_ext;
  logic [SUM_W-1:0] sum_wide;
  logic             add_ovf;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] count_inc;
  logic             term_limit;
  logic             accept;

  // A stale done from the multiplier blocks acceptance of a new pair.
  assign in_ready = (state == S_IDLE) && !mul_done;
  assign accept   = in_valid && in_ready;

  // Accumulate at ACC_W+1 bits; the two top bits disagree exactly when two
  // same-signed addends produced a sum of the other sign.
  assign prod_ext = ACC_W'($signed(prod_q));
  assign sum_wide = {acc_result[ACC_W-1], acc_result} + {prod_ext[ACC_W-1], prod_ext};
  assign add_ovf  = sum_wide[ACC_W] != sum_wide[ACC_W-1];

`ifdef SATURATE_EN
  // Clamp towards the sign of the addends (both addends share it on overflow).
  always_comb begin
    acc_next = sum_wide[ACC_W-1:0];
    if (add_ovf) begin
      if (prod_ext[ACC_W-1]) begin
        acc_next = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        acc_next = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end
  end
`else
  // Wrap modulo 2^ACC_W.
  assign acc_next = sum_wide[ACC_W-1:0];
`endif

  assign count_inc  = acc_count + CNT_W'(1);
  assign term_limit = count_inc == CNT_W'(MAX_TERMS);

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      last_q     <= 1'b0;
      prod_q     <= '0;
      mul_start  <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      acc_valid  <= 1'b0;
      acc_result <= '0;
      acc_count  <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            mul_a     <= in_a;
            mul_b     <= in_b;
            last_q    <= in_last;
            mul_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (mul_done) begin
            prod_q    <= mul_product;
            mul_start <= 1'b0;
            state     <= S_RELEASE;
          end
        end

        // Wait for the multiplier to drop done before the next term.
        S_RELEASE: begin
          if (!mul_done) begin
            state <= S_ACCUM;
          end
        end

        S_ACCUM: begin
          acc_result <= acc_next;
          acc_count  <= count_inc;
          if (add_ovf) begin
            overflow <= 1'b1;
          end
          if (last_q || term_limit) begin
            acc_valid <= 1'b1;
            state     <= S_OUT;
          end else begin
            state <= S_IDLE;
          end
        end

        S_OUT: begin
          if (acc_ready) begin
            acc_valid  <= 1'b0;
            acc_result <= '0;
            acc_count  <= '0;
            overflow   <= 1'b0;
            state      <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          mul_start <= 1'b0;
          acc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
